request_arbiter: RTL and testbench
==================================

// Module: request_arbiter
// PURPOSE
//  Round-robin arbiter directly upstream of the request mux. Watches the
//  REQ_NUMBER request-valid lines and drives the mux select plus a
//  valid/ready handshake toward the consumer of the selected request.
//  Holds the select stable until the consumer accepts, then acks the winner.
// PARAMETERS
//  REQ_NUMBER  16  number of requesters; >=2; need not be a power of two
//  CNT_WIDTH   16  width of grant_count (optional feature only)
// PORTS
//  clk          in   1                    clock; all logic on rising edge
//  rst_n        in   1                    async assert, active-low reset; sync release
//  req_valid    in   REQ_NUMBER           per-requester request pending
//  req_ack      out  REQ_NUMBER           one-hot, 1-cycle pulse: request consumed
//  select       out  $clog2(REQ_NUMBER)   index of the granted requester, to mux
//  out_valid    out  1                    select is valid; selected request presented
//  out_ready    in   1                    consumer accepts the selected request
//  grant_count  out  CNT_WIDTH            accepted-grant count (REQUEST_ARBITER_CNT_EN)
// BEHAVIOUR
//  - All outputs are registered. Reset values: select=0, out_valid=0,
//    req_ack=0, ptr=REQ_NUMBER-1 (requester 0 has first priority), grant_count=0.
//  - State machine:
//    IDLE -> GRANT when any req_valid=1: select = first set index searching
//      ptr+1, ptr+2, ... with wrap modulo REQ_NUMBER; out_valid=1 next cycle.
//      Latency is 1 cycle from req_valid to out_valid.
//    GRANT with out_ready=0: hold select and out_valid; ignore req_valid changes.
//    GRANT with out_ready=1 (handshake): ptr<=select;
//      req_ack[select] pulses for exactly 1 cycle.
//      Then, in the same edge, re-arbitrate from the new ptr over
//      req_valid & ~onehot(select).
//      If any remain, stay GRANT with the new select, giving back-to-back
//      grants at 1 per cycle. Otherwise go to IDLE with out_valid=0.
//  - Protocol: a requester holds req_valid until it sees req_ack. A
//    req_valid drop while granted is a protocol error. The grant is still
//    held and completed.
//  - A single requester that is continuously valid gets a grant every other
//    cycle, because its own just-acked bit is masked. Multiple requesters
//    rotate strictly.
//  - Wrap-around: the search from ptr=REQ_NUMBER-1 starts at 0. For a
//    non-power-of-two REQ_NUMBER, indices >= REQ_NUMBER are never produced.
//  - out_ready while out_valid=0 is ignored.
//  - Reset mid-GRANT: out_valid drops immediately (async). No req_ack is
//    issued and ptr returns to REQ_NUMBER-1.
//  - The state machine has 2 states; encode IDLE/GRANT explicitly, with no
//    implicit latch on out_valid.
// CONFIGURATION
//  REQUEST_ARBITER_CNT_EN defined: grant_count increments by 1 on each
//    handshake and saturates at 2**CNT_WIDTH-1 (no wrap).
//  REQUEST_ARBITER_CNT_EN undefined: no counter logic; grant_count is tied to 0.
//  Arbitration timing is identical with and without the macro.
// TESTING
//  1 Reset release, req_valid=0 -> out_valid=0, select=0, req_ack=0 indefinitely.
//  2 req_valid=16'h0001 with out_ready=1 -> out_valid the next cycle,
//    select=0, req_ack=16'h0001 one cycle, then IDLE.
//  3 req_valid=16'h8421 held, out_ready=1 -> select sequence 0,5,10,15,0,...
//    with out_valid continuously 1.
//  4 req_valid=16'h0006, out_ready=0 for 5 cycles -> select=1 stable, no ack;
//    on out_ready=1 -> ack[1], next select=2.
//  5 ptr=14 after a grant to 14; req_valid=16'h0009 -> select=0 (wrap), then 3.
//  6 Assert rst_n=0 mid-GRANT -> out_valid=0 at once; no ack; after release,
//    the first grant is the lowest set index.
//    With REQUEST_ARBITER_CNT_EN: 3 handshakes -> grant_count=3.

Source files
------------

// File: rtl/request_arbiter.sv
// Round-robin arbiter feeding the request mux with a valid/ready handshake toward the consumer.
// Define REQUEST_ARBITER_CNT_EN to build the saturating accepted-grant counter on grant_count.
module request_arbiter #(
    parameter int REQ_NUMBER = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [REQ_NUMBER-1:0]         req_valid,
    output logic [REQ_NUMBER-1:0]         req_ack,
    output logic [$clog2(REQ_NUMBER)-1:0] select,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CNT_WIDTH-1:0]          grant_count
);

    localparam int SEL_W = $clog2(REQ_NUMBER);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [SEL_W-1:0]        ptr;
    logic [SEL_W-1:0]        ptr_next;
    logic [SEL_W-1:0]        select_next;
    logic [REQ_NUMBER-1:0]   ack_next;
    logic [REQ_NUMBER-1:0]   sel_onehot;
    logic [SEL_W-1:0]        search_ptr;
    logic [REQ_NUMBER-1:0]   search_mask;
    logic                    arb_found;
    logic [SEL_W-1:0]        arb_idx;
    logic                    handshake;

    assign handshake  = (state == GRANT) && out_ready;
    assign sel_onehot = REQ_NUMBER'(1) << select;

    // While granted, the next winner is searched from the current select with its own bit masked.
    assign search_ptr  = (state == GRANT) ? select : ptr;
    assign search_mask = (state == GRANT) ? (req_valid & ~sel_onehot) : req_valid;

    always_comb begin
        int cand;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        for (int i = 1; i <= REQ_NUMBER; i++) begin
            cand = int'(search_ptr) + i;
            if (cand >= REQ_NUMBER) begin
                cand = cand - REQ_NUMBER;
            end
            if (!arb_found && search_mask[cand]) begin
                arb_found = 1'b1;
                arb_idx   = SEL_W'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (arb_found) state_next = GRANT;
            GRANT:   if (out_ready && !arb_found) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        select_next = select;
        ptr_next    = ptr;
        ack_next    = '0;
        case (state)
            IDLE: begin
                if (arb_found) begin
                    select_next = arb_idx;
                end
            end
            GRANT: begin
                if (out_ready) begin
                    ptr_next = select;
                    ack_next = sel_onehot;
                    if (arb_found) begin
                        select_next = arb_idx;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            select    <= '0;
            out_valid <= 1'b0;
            req_ack   <= '0;
            ptr       <= SEL_W'(REQ_NUMBER - 1);
        end else begin
            select    <= select_next;
            out_valid <= (state_next == GRANT);
            req_ack   <= ack_next;
            ptr       <= ptr_next;
        end
    end

`ifdef REQUEST_ARBITER_CNT_EN
    logic [CNT_WIDTH-1:0] count_q;

    // Saturates rather than wraps so a stuck-high count is distinguishable from a reset one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (handshake && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign grant_count = count_q;
`else
    assign grant_count = '0;
`endif

endmodule

// File: tb/tb_request_arbiter.sv
// Scoreboard bench for request_arbiter: a reference model queues expected outputs, a monitor pops and compares.
// Directed scenarios followed by randomized request/ready traffic.
module tb_request_arbiter;

    localparam int N   = 16;
    localparam int SW  = $clog2(N);
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ack;
    logic [SW-1:0] select;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] grant_count;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int           sel;
        bit           valid;
        logic [N-1:0] ack;
    } exp_t;

    exp_t exp_q[$];

    bit  m_busy  = 1'b0;
    int  m_sel   = 0;
    int  m_ptr   = N - 1;
    longint m_count = 0;

    request_arbiter #(.REQ_NUMBER(N), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ack     (req_ack),
        .select      (select),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .grant_count (grant_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] req, input logic ready, input int cycles);
        @(negedge clk);
        req_valid = req;
        out_ready = ready;
        repeat (cycles - 1) @(negedge clk);
    endtask

    // Round-robin search: first set bit strictly after 'from', wrapping modulo N.
    function automatic int pick(input int from, input logic [N-1:0] m);
        for (int k = 1; k <= N; k++) begin
            if (m[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [N-1:0] ack;
        logic [N-1:0] mask;
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_sel   = 0;
            m_ptr   = N - 1;
            m_count = 0;
            exp_q.delete();
        end else begin
            ack = '0;
            if (!m_busy) begin
                if (req_valid != '0) begin
                    m_sel  = pick(m_ptr, req_valid);
                    m_busy = 1'b1;
                end
            end else if (out_ready) begin
                ack   = '0;
                ack[m_sel] = 1'b1;
                m_ptr = m_sel;
                if (m_count < (64'd1 << CW) - 1) m_count++;
                mask = req_valid & ~ack;
                if (mask != '0) m_sel = pick(m_ptr, mask);
                else m_busy = 1'b0;
            end
            if (m_busy || ack != '0) exp_q.push_back('{sel: m_sel, valid: m_busy, ack: ack});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (out_valid || req_ack != '0)) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_output", {out_valid, req_ack}, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("out_valid", out_valid, e.valid);
                checkOutput("req_ack", req_ack, e.ack);
                if (e.valid) checkOutput("select", select, e.sel);
            end
        end
    end

    initial begin
        longint exp_cnt;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: nothing presented, select parked at 0.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("reset_out_valid", out_valid, 0);
            checkOutput("reset_select", select, 0);
            checkOutput("reset_req_ack", req_ack, 0);
            checkOutput("reset_grant_count", grant_count, 0);
        end

        applyStimulus(16'h0001, 1'b1, 2);
        applyStimulus(16'h0000, 1'b1, 3);

        applyStimulus(16'h0006, 1'b0, 6);
        applyStimulus(16'h0006, 1'b1, 1);
        applyStimulus(16'h0004, 1'b1, 1);
        applyStimulus(16'h0000, 1'b0, 3);

        applyStimulus(16'h8421, 1'b1, 9);
        applyStimulus(16'h0000, 1'b0, 3);

        applyStimulus(16'h4000, 1'b1, 2);
        applyStimulus(16'h0009, 1'b1, 4);
        applyStimulus(16'h0000, 1'b0, 3);

        // Async reset in the middle of a held grant.
        applyStimulus(16'h0300, 1'b0, 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_req_ack", req_ack, 0);
        checkOutput("midreset_select", select, 0);
        checkOutput("midreset_grant_count", grant_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(16'h0120, 1'b1, 4);
        applyStimulus(16'h0000, 1'b0, 3);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            req_valid = N'($urandom) & N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
        end

        applyStimulus(16'h0000, 1'b1, 4);
        applyStimulus(16'h0000, 1'b0, 2);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
`ifdef REQUEST_ARBITER_CNT_EN
        exp_cnt = m_count;
`else
        exp_cnt = 0;
`endif
        checkOutput("grant_count", grant_count, exp_cnt);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
